// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - byte-source and buart-side signals of the UART TX arbiter
//
// Purpose: groups the two byte-source ports (A: CPU I/O, B: auxiliary) and the
// buart transmit handshake into one bundle.
// Signals:
//   a_wr/a_data/a_full          port A write strobe, byte, holding register occupied
//   b_wr/b_data/b_full/b_lock   port B write strobe, byte, occupied, keep-grant request
//   tx_wr/tx_data/tx_busy       buart write strobe, byte, transmitter busy
//   last_b                      last launched byte came from port B
// Modports:
//   master  byte sources plus buart (drives writes and tx_busy)
//   slave   the arbiter
interface uart_tx_arbiter_if;
  logic       a_wr;
  logic [7:0] a_data;
  logic       a_full;
  logic       b_wr;
  logic [7:0] b_data;
  logic       b_full;
  logic       b_lock;
  logic       tx_wr;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic       last_b;

  modport master (
    output a_wr, a_data, b_wr, b_data, b_lock, tx_busy,
    input  a_full, b_full, tx_wr, tx_data, last_b
  );

  modport slave (
    input  a_wr, a_data, b_wr, b_data, b_lock, tx_busy,
    output a_full, b_full, tx_wr, tx_data, last_b
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin sharing of one buart transmitter between two byte sources
//
// Purpose: each port owns a one-byte holding register; an FSM picks a full
// register when the buart is idle, pulses tx_wr for one cycle, then waits for
// tx_busy to rise (bounded by BUSY_WAIT cycles) and fall before the next pick.
// Ports:
//   clk    system clock
//   reset  asynchronous reset, active high
//   bus    uart_tx_arbiter_if.slave (holding-register writes, buart handshake)
// Parameters:
//   BUSY_WAIT  cycles after tx_wr to wait for tx_busy before assuming the byte left
// Build option:
//   UART_ARB_LOCK_EN  when defined, a B launch with b_lock=1 keeps the grant on B
//                     for as long as b_lock stays high; otherwise b_lock is ignored.
module uart_tx_arbiter #(
  parameter int BUSY_WAIT = 4
) (
  input logic          clk,
  input logic          reset,
  uart_tx_arbiter_if.slave bus
);
  localparam int CW = $clog2(BUSY_WAIT) + 1;

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_RISE, WAIT_FALL} state_t;

  state_t        state_q, state_d;
  logic          a_full_q, a_full_d;
  logic          b_full_q, b_full_d;
  logic [7:0]    a_data_q, a_data_d;
  logic [7:0]    b_data_q, b_data_d;
  logic          tx_wr_q, tx_wr_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          last_b_q, last_b_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          grant_a, grant_b;
  logic          locked;

`ifdef UART_ARB_LOCK_EN
  logic lock_q, lock_d;

  // The lock only holds while b_lock stays high; once it drops, a later rise
  // does not re-arm it until B launches again.
  assign locked = lock_q & bus.b_lock;

  always_comb begin
    lock_d = lock_q & bus.b_lock;
    if (grant_b) lock_d = bus.b_lock;
    if (grant_a) lock_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) lock_q <= 1'b0;
    else       lock_q <= lock_d;
  end
`else
  logic unused_b_lock;
  assign unused_b_lock = bus.b_lock;
  assign locked        = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    a_full_d  = a_full_q;
    b_full_d  = b_full_q;
    a_data_d  = a_data_q;
    b_data_d  = b_data_q;
    tx_wr_d   = 1'b0;
    tx_data_d = tx_data_q;
    last_b_d  = last_b_q;
    cnt_d     = cnt_q;
    grant_a   = 1'b0;
    grant_b   = 1'b0;

    // Arbitration: only in IDLE with the buart free. On a tie the port that
    // did not send last wins.
    if (state_q == IDLE && !bus.tx_busy) begin
      if (locked) begin
        grant_b = b_full_q;
      end else if (a_full_q && b_full_q) begin
        grant_a = last_b_q;
        grant_b = !last_b_q;
      end else begin
        grant_a = a_full_q;
        grant_b = b_full_q;
      end
    end

    case (state_q)
      IDLE: begin
        if (grant_a || grant_b) state_d = LAUNCH;
      end
      LAUNCH: begin
        state_d = WAIT_RISE;
        cnt_d   = '0;
      end
      WAIT_RISE: begin
        if (bus.tx_busy) begin
          state_d = WAIT_FALL;
        end else if (cnt_q == CW'(BUSY_WAIT - 1)) begin
          state_d = IDLE;
        end else if (cnt_q != {CW{1'b1}}) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_FALL: begin
        if (!bus.tx_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // The grant registers the byte so that tx_wr/tx_data are visible, and the
    // holding register already released, during the LAUNCH cycle.
    if (grant_a) begin
      tx_wr_d   = 1'b1;
      tx_data_d = a_data_q;
      last_b_d  = 1'b0;
      a_full_d  = 1'b0;
    end
    if (grant_b) begin
      tx_wr_d   = 1'b1;
      tx_data_d = b_data_q;
      last_b_d  = 1'b1;
      b_full_d  = 1'b0;
    end

    // Testing the post-release value lets a write in the release cycle load.
    if (bus.a_wr && !a_full_d) begin
      a_full_d = 1'b1;
      a_data_d = bus.a_data;
    end
    if (bus.b_wr && !b_full_d) begin
      b_full_d = 1'b1;
      b_data_d = bus.b_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      a_full_q  <= 1'b0;
      b_full_q  <= 1'b0;
      a_data_q  <= 8'h00;
      b_data_q  <= 8'h00;
      tx_wr_q   <= 1'b0;
      tx_data_q <= 8'h00;
      last_b_q  <= 1'b1;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      a_full_q  <= a_full_d;
      b_full_q  <= b_full_d;
      a_data_q  <= a_data_d;
      b_data_q  <= b_data_d;
      tx_wr_q   <= tx_wr_d;
      tx_data_q <= tx_data_d;
      last_b_q  <= last_b_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.a_full  = a_full_q;
  assign bus.b_full  = b_full_q;
  assign bus.tx_wr   = tx_wr_q;
  assign bus.tx_data = tx_data_q;
  assign bus.last_b  = last_b_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  uart_tx_arbiter_if bus ();

  uart_tx_arbiter #(.BUSY_WAIT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_run  = 0;
  int n_fail = 0;

  // buart model: busy for 10 cycles after each wr, unaffected by arbiter reset
  int busy_cnt = 0;
  bit busy_en  = 1'b1;
  always @(posedge clk) begin
    if (bus.tx_wr && busy_en) busy_cnt <= 10;
    else if (busy_cnt > 0)    busy_cnt <= busy_cnt - 1;
  end
  assign bus.tx_busy = (busy_cnt != 0);

  // launch monitor
  int         cyc     = 0;
  int         viol    = 0;
  bit         prev_wr = 1'b0;
  logic [7:0] sent_q[$];
  int         launch_cyc[$];
  logic [7:0] exp_q[$];

  always @(negedge clk) begin
    cyc     <= cyc + 1;
    prev_wr <= bus.tx_wr;
    if (bus.tx_wr) begin
      sent_q.push_back(bus.tx_data);
      launch_cyc.push_back(cyc);
      if (bus.tx_busy || prev_wr) viol <= viol + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(1);
  endtask

  task automatic wr(input bit a_en, input logic [7:0] a_d, input bit b_en, input logic [7:0] b_d);
    bus.a_wr   = a_en;
    bus.a_data = a_d;
    bus.b_wr   = b_en;
    bus.b_data = b_d;
    @(negedge clk);
    bus.a_wr = 1'b0;
    bus.b_wr = 1'b0;
  endtask

  task automatic wait_tx(input string tag);
    int k = 0;
    while (!bus.tx_wr && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!bus.tx_wr) check({tag, "_tx_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_bfree(input string tag);
    int k = 0;
    while (bus.b_full && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (bus.b_full) check({tag, "_bfree_timeout"}, 32'd1, 32'd0);
  endtask

  task automatic drain(input string tag);
    int k = 0;
    while ((bus.a_full || bus.b_full || bus.tx_busy) && k < 300) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_drain"}, {29'd0, bus.a_full, bus.b_full, bus.tx_busy}, 32'd0);
    tick(8);
  endtask

  task automatic check_sent(input string tag);
    check({tag, "_count"}, sent_q.size(), exp_q.size());
    foreach (exp_q[i])
      if (i < sent_q.size()) check($sformatf("%s_byte%0d", tag, i), sent_q[i], exp_q[i]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bus.a_wr = 1'b0; bus.a_data = 8'h00;
    bus.b_wr = 1'b0; bus.b_data = 8'h00;
    bus.b_lock = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(1);

    check("rst_a_full",  bus.a_full,  0);
    check("rst_b_full",  bus.b_full,  0);
    check("rst_tx_wr",   bus.tx_wr,   0);
    check("rst_tx_data", bus.tx_data, 0);
    check("rst_last_b",  bus.last_b,  1);

    // single byte on idle arbiter: tx_wr two cycles after the write
    sent_q.delete();
    wr(1, 8'h41, 0, 8'h00);
    check("t1_a_full_loaded", bus.a_full, 1);
    check("t1_no_early_wr",   bus.tx_wr,  0);
    @(negedge clk);
    check("t1_tx_wr",         bus.tx_wr,   1);
    check("t1_tx_data",       bus.tx_data, 8'h41);
    check("t1_a_full_clear",  bus.a_full,  0);
    @(negedge clk);
    check("t1_pulse_ends",    bus.tx_wr,   0);
    check("t1_busy_seen",     bus.tx_busy, 1);
    drain("t1");
    check("t1_data_held",     bus.tx_data, 8'h41);
    exp_q = {8'h41};
    check_sent("t1");

    // tie after reset: A first, then B
    do_reset();
    sent_q.delete();
    wr(1, 8'h11, 1, 8'h22);
    drain("t2");
    exp_q = {8'h11, 8'h22};
    check_sent("t2");
    check("t2_last_b", bus.last_b, 1);

    // write to a full register is dropped
    sent_q.delete();
    wr(0, 8'h00, 1, 8'h66);
    wait_tx("t3");
    wr(1, 8'h55, 0, 8'h00);
    check("t3_a_full", bus.a_full, 1);
    wr(1, 8'h77, 0, 8'h00);
    check("t3_a_full_kept", bus.a_full, 1);
    drain("t3");
    exp_q = {8'h66, 8'h55};
    check_sent("t3");

    // busy never rises: timeout after BUSY_WAIT, then next byte (B wins, last_b=0)
    busy_en = 1'b0;
    sent_q.delete();
    launch_cyc.delete();
    wr(1, 8'h01, 1, 8'h02);
    drain("t4");
    exp_q = {8'h02, 8'h01};
    check_sent("t4");
    if (launch_cyc.size() == 2) check("t4_gap", launch_cyc[1] - launch_cyc[0], 6);
    busy_en = 1'b1;

    // B with b_lock while A pending
    do_reset();
    sent_q.delete();
    bus.b_lock = 1'b1;
    wr(0, 8'h00, 1, 8'hB1);
    wait_tx("t5");
    wr(1, 8'hA1, 1, 8'hB2);
    wait_bfree("t5a");
    wr(0, 8'h00, 1, 8'hB3);
    wait_bfree("t5b");
    bus.b_lock = 1'b0;
    drain("t5");
`ifdef UART_ARB_LOCK_EN
    exp_q = {8'hB1, 8'hB2, 8'hB3, 8'hA1};
`else
    exp_q = {8'hB1, 8'hA1, 8'hB2, 8'hB3};
`endif
    check_sent("t5");

    // reset while buart frame still in flight
    sent_q.delete();
    wr(1, 8'h5A, 0, 8'h00);
    wait_tx("t6");
    tick(3);
    wr(0, 8'h00, 1, 8'h5B);
    check("t6_b_pending", bus.b_full, 1);
    reset = 1'b1;
    tick(1);
    check("t6_rst_a_full",  bus.a_full,  0);
    check("t6_rst_b_full",  bus.b_full,  0);
    check("t6_rst_tx_data", bus.tx_data, 0);
    reset = 1'b0;
    wr(1, 8'h33, 0, 8'h00);
    check("t6_busy_still", bus.tx_busy, 1);
    check("t6_held_off",   bus.tx_wr,   0);
    drain("t6");
    exp_q = {8'h5A, 8'h33};
    check_sent("t6");

    check("tx_wr_while_busy_or_long", viol, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
